// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// A request is accepted, and its data returned, in the cycle imem_ack is high.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: FETCH issues a read, HOLD presents the word to decode
// until released, TRAP parks the stage after a misaligned redirect until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               stall,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [6:0]         opcode,
  output logic [2:0]         fun3,
  output logic               fun7,
  output logic               misaligned
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        misaligned_reg, misaligned_next;

  logic        redirect_aligned;

  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FETCH;
      fetch_pc_reg   <= RESET_PC;
      pc_reg         <= RESET_PC;
      instr_reg      <= NOP_INSTR;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      misaligned_reg <= misaligned_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    misaligned_next = misaligned_reg;

    case (state_reg)
      FETCH: begin
        // A same-cycle redirect wins over the ack; the returned word is dropped.
        if (redirect) begin
          if (redirect_aligned) begin
            fetch_pc_next = redirect_pc;
            state_next    = FETCH;
          end else begin
            misaligned_next = 1'b1;
            state_next      = TRAP;
          end
        end else if (imem.imem_ack) begin
          instr_next = imem.imem_rdata;
          pc_next    = fetch_pc_reg;
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          if (redirect_aligned) begin
            fetch_pc_next = redirect_pc;
            state_next    = FETCH;
          end else begin
            misaligned_next = 1'b1;
            state_next      = TRAP;
          end
        end else if (!stall) begin
          fetch_pc_next = pc_reg + 32'd4;
          state_next    = FETCH;
        end
      end

      TRAP: begin
        state_next = TRAP;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Outputs are forced idle while reset is asserted, whatever the old state was.
  assign imem.imem_req  = (state_reg == FETCH) && !rst;
  assign imem.imem_addr = fetch_pc_reg;
  assign instr_valid    = (state_reg == HOLD) && !rst;

  assign instr      = instr_reg;
  assign pc         = pc_reg;
  assign pc_plus4   = pc_reg + 32'd4;
  assign opcode     = instr_reg[6:0];
  assign fun3       = instr_reg[14:12];
  assign fun7       = instr_reg[30];
  assign misaligned = misaligned_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, both checked against a cycle-level behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic        fun7;
  logic        misaligned;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .opcode      (opcode),
    .fun3        (fun3),
    .fun7        (fun7),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;

  // Behavioural model: what the fetch stage currently holds.
  bit          m_init    = 1'b0;
  bit          m_trapped = 1'b0;
  bit          m_have    = 1'b0;   // an instruction is being presented to decode
  logic [31:0] m_next_addr;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_mis;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outputs();
    bit exp_req;
    bit exp_valid;
    if (!m_init) return;
    exp_req   = !rst && !m_trapped && !m_have;
    exp_valid = !rst && !m_trapped && m_have;
    check_value("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
    check_value("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
    if (exp_req) check_value("imem_addr", bus.imem_addr, m_next_addr);
    check_value("instr", instr, m_instr);
    check_value("pc", pc, m_pc);
    check_value("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_value("opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
    check_value("fun3", {29'd0, fun3}, {29'd0, m_instr[14:12]});
    check_value("fun7", {31'd0, fun7}, {31'd0, m_instr[30]});
    check_value("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
  endtask

  // Apply the rules for one clock edge with the currently driven inputs.
  task automatic model_edge();
    if (rst) begin
      m_init      = 1'b1;
      m_trapped   = 1'b0;
      m_have      = 1'b0;
      m_next_addr = RESET_PC;
      m_pc        = RESET_PC;
      m_instr     = NOP_INSTR;
      m_mis       = 1'b0;
    end else if (!m_init || m_trapped) begin
      // nothing changes
    end else if (redirect) begin
      if (redirect_pc % 4 != 0) begin
        m_mis     = 1'b1;
        m_trapped = 1'b1;
      end else begin
        m_next_addr = redirect_pc;
        m_have      = 1'b0;
      end
    end else if (!m_have) begin
      if (bus.imem_ack) begin
        m_instr = bus.imem_rdata;
        m_pc    = m_next_addr;
        m_have  = 1'b1;
      end
    end else if (!stall) begin
      m_next_addr = m_pc + 32'd4;
      m_have      = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic ack, input logic [31:0] rdata,
                      input logic rd, input logic [31:0] rpc, input logic st);
    rst            = r;
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
    redirect       = rd;
    redirect_pc    = rpc;
    stall          = st;
    #1;
    check_outputs();
    model_edge();
    $display("cycle t=%0t rst=%0b ack=%0b rdata=%h redir=%0b rpc=%h stall=%0b -> req=%0b addr=%h valid=%0b pc=%h mis=%0b",
             $time, r, ack, rdata, rd, rpc, st, bus.imem_req, bus.imem_addr,
             instr_valid, pc, misaligned);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then first fetch.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    check_value("rst_instr_nop", instr, 32'h0000_0013);
    check_value("rst_valid", {31'd0, instr_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
    check_value("d034_valid", {31'd0, instr_valid}, 32'd1);
    check_value("d034_pc", pc, 32'h0);
    check_value("d034_opcode", {25'd0, opcode}, 32'h13);
    check_value("d034_fun3", {29'd0, fun3}, 32'h0);
    check_value("d034_pc_plus4", pc_plus4, 32'h4);

    // Stall holds the instruction; release fetches pc+4.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
      check_value("d035_req", {31'd0, bus.imem_req}, 32'd0);
      check_value("d035_instr", instr, 32'h0050_0093);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_value("d035_addr", bus.imem_addr, 32'h4);

    // Redirect beats a same-cycle ack.
    step(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h100, 1'b0);
    check_value("d036_addr", bus.imem_addr, 32'h100);
    check_value("d036_valid", {31'd0, instr_valid}, 32'd0);
    check_value("d036_instr", instr, 32'h0050_0093);

    // Redirect beats stall in HOLD.
    step(1'b0, 1'b1, 32'h0000_0113, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    check_value("d037_addr", bus.imem_addr, 32'h200);
    check_value("d037_req", {31'd0, bus.imem_req}, 32'd1);

    // pc wraps from the top of the address space.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0213, 1'b0, 32'h0, 1'b0);
    check_value("d039_pc", pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_value("d039_addr", bus.imem_addr, 32'h0);

    // Misaligned redirect traps until reset.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0);
    check_value("d038_mis", {31'd0, misaligned}, 32'd1);
    check_value("d038_req", {31'd0, bus.imem_req}, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0313, 1'b1, 32'h300, 1'b0);
    check_value("d038_mis_hold", {31'd0, misaligned}, 32'd1);
    check_value("d038_req_hold", {31'd0, bus.imem_req}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_value("d038_mis_clr", {31'd0, misaligned}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_value("d038_restart", bus.imem_addr, RESET_PC);
    check_value("d038_restart_req", {31'd0, bus.imem_req}, 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_ack, r_rd, r_st;
      logic [31:0] r_rpc;
      r_rst = ($urandom_range(0, 99) < 3);
      r_ack = ($urandom_range(0, 99) < 50);
      r_st  = ($urandom_range(0, 99) < 50);
      r_rd  = ($urandom_range(0, 99) < 12);
      r_rpc = $urandom;
      if ($urandom_range(0, 7) != 0) r_rpc[1:0] = 2'b00;
      step(r_rst, r_ack, $urandom, r_rd, r_rpc, r_st);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1, instruction memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-006 The block SHALL have port imem_ack, input, 1, memory accepts the request and returns data in the same cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32, instruction word, valid only when imem_ack=1.
REQ-008 The block SHALL have port redirect, input, 1, taken Jal/Jalr/Branch from execute.
REQ-009 The block SHALL have port redirect_pc, input, 32, jump or branch target.
REQ-010 The block SHALL have port stall, input, 1, downstream holds the current instruction.
REQ-011 The block SHALL have port instr_valid, output, 1, instr/pc/fields are valid for decode.
REQ-012 The block SHALL have port instr, output, 32, registered instruction word.
REQ-013 The block SHALL have port pc, output, 32, address of instr.
REQ-014 The block SHALL have port pc_plus4, output, 32, pc+4 for the Jal/Jalr link write.
REQ-015 The block SHALL have ports opcode (7, instr[6:0]), fun3 (3, instr[14:12]) and fun7 (1, instr[30]), all outputs feeding the control unit.
REQ-016 The block SHALL have port misaligned, output, 1, sticky trap flag for a redirect target not 4-byte aligned.

Function
REQ-017 The block SHALL implement a state machine with states FETCH, HOLD and TRAP.
REQ-018 In FETCH: imem_req=1, imem_addr=fetch_pc, and instr_valid=0.
REQ-019 In FETCH with imem_ack=1 and redirect=0: instr<=imem_rdata, pc<=fetch_pc, and the state goes to HOLD.
REQ-020 Fetch latency SHALL be one cycle: an ack in cycle N gives instr_valid=1 in cycle N+1.
REQ-021 In HOLD: instr_valid=1 and imem_req=0; instr and pc hold while stall=1.
REQ-022 In HOLD with stall=0 and redirect=0: fetch_pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), and the state goes to FETCH.
REQ-023 A redirect with redirect_pc[1:0]==0, in FETCH or HOLD: fetch_pc<=redirect_pc, the state goes to FETCH, and instr_valid=0 next cycle.
REQ-024 Redirect SHALL have priority over stall.
REQ-025 Redirect SHALL have priority over an imem_ack in the same cycle; the returned word is discarded and never presented.
REQ-026 A redirect with redirect_pc[1:0]!=0 SHALL cause misaligned<=1 and the state to go to TRAP; fetch_pc and pc are left unchanged.
REQ-027 In TRAP: imem_req=0, instr_valid=0, and redirect, stall and imem_ack are ignored; only rst exits.
REQ-028 imem_ack while imem_req=0 SHALL be ignored.
REQ-029 pc_plus4 SHALL equal pc+4 combinationally; opcode, fun3 and fun7 SHALL be combinational slices of instr.
REQ-030 No request SHALL be dropped without a redirect; FETCH waits indefinitely for imem_ack.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL enter FETCH with fetch_pc=RESET_PC, pc=RESET_PC, instr=32'h0000_0013 (NOP), and misaligned=0.
REQ-032 rst SHALL override every other input, including mid-fetch, HOLD and TRAP; an in-flight ack in the reset cycle is discarded.
REQ-033 During reset and in the following cycle, instr_valid=0; imem_req=1 from the first cycle after rst deasserts.

Verification
REQ-034 Reset, then imem_ack=1 with rdata=32'h0050_0093 at cycle 1 -> cycle 2: instr_valid=1, pc=0, opcode=7'h13, fun3=0, pc_plus4=4.
REQ-035 HOLD with stall=1 for 3 cycles -> instr and pc constant and imem_req=0; stall drops -> next cycle imem_addr=32'h4.
REQ-036 FETCH with imem_ack=1 and redirect=1, redirect_pc=32'h100 in the same cycle -> rdata discarded, next cycle imem_addr=32'h100 and instr_valid=0.
REQ-037 HOLD with stall=1 and redirect=1, redirect_pc=32'h200 -> next cycle FETCH at 32'h200.
REQ-038 redirect=1 with redirect_pc=32'h102 -> misaligned=1, imem_req=0 and remains so under further redirects; rst=1 -> misaligned=0 and fetch restarts at RESET_PC.
REQ-039 pc=32'hFFFF_FFFC in HOLD, stall=0 -> next imem_addr=32'h0000_0000.
